// File: rtl/mnist_frame_reader.sv
// mnist_frame_reader: snapshots a 28x28 one-bit drawing and streams it out
// one pixel per beat over a valid/ready handshake, counting set pixels.
//
// Handshake: a beat transfers on a rising edge where out_valid and out_ready
// are both high. While out_valid is high and out_ready is low, every output
// holds its value. out_valid never drops inside a frame unless abort or reset.
module mnist_frame_reader #(
    parameter int GRID_SIZE  = 28,
    parameter int NUM_PIXELS = 784,
    parameter int PIXEL_W    = 8,
    parameter logic [PIXEL_W-1:0] ON_VALUE  = 8'd255,
    parameter logic [PIXEL_W-1:0] OFF_VALUE = 8'd0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_PIXELS-1:0] pixel_memory,
    output logic                  busy,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIXEL_W-1:0]    out_data,
    output logic [9:0]            out_index,
    output logic [4:0]            out_row,
    output logic [4:0]            out_col,
    output logic                  out_last,
    output logic                  done,
    output logic [9:0]            ones_count
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [NUM_PIXELS-1:0] snap_q, snap_d;
    logic [9:0]            idx_q, idx_d;
    logic [4:0]            row_q, row_d;
    logic [4:0]            col_q, col_d;
    logic [9:0]            ones_q, ones_d;

    logic cur_bit;
    logic last_beat;
    logic xfer;

    // Snapshot bit at the current cell and transfer qualifiers; abort
    // outranks a same-cycle transfer so the aborted beat is never counted.
    assign cur_bit   = snap_q[idx_q];
    assign last_beat = (idx_q == 10'(NUM_PIXELS - 1));
    assign xfer      = (state_q == S_STREAM) && out_ready && !abort;

    // State register with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Next-state logic; illegal encodings fall back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_STREAM;
            S_STREAM: begin
                if (abort)                  state_d = S_IDLE;
                else if (xfer && last_beat) state_d = S_DONE;
            end
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state and datapath registers only.
    always_comb begin
        out_valid  = (state_q == S_STREAM);
        busy       = (state_q == S_STREAM) || (state_q == S_DONE);
        done       = (state_q == S_DONE);
        out_data   = (out_valid && cur_bit) ? ON_VALUE : OFF_VALUE;
        out_last   = out_valid && last_beat;
        out_index  = idx_q;
        out_row    = row_q;
        out_col    = col_q;
        ones_count = ones_q;
    end

    // Datapath next values: capture on start, advance the cell walk on a
    // transfer. row/col are walked alongside index so no divider is needed.
    always_comb begin
        snap_d = snap_q;
        idx_d  = idx_q;
        row_d  = row_q;
        col_d  = col_q;
        ones_d = ones_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    snap_d = pixel_memory;
                    idx_d  = '0;
                    row_d  = '0;
                    col_d  = '0;
                    ones_d = '0;
                end
            end
            S_STREAM: begin
                if (xfer) begin
                    ones_d = ones_q + 10'(cur_bit);
                    if (!last_beat) begin
                        idx_d = idx_q + 10'd1;
                        if (col_q == 5'(GRID_SIZE - 1)) begin
                            col_d = '0;
                            row_d = row_q + 5'd1;
                        end else begin
                            col_d = col_q + 5'd1;
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset clears the snapshot and all counters.
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            snap_q <= '0;
            idx_q  <= '0;
            row_q  <= '0;
            col_q  <= '0;
            ones_q <= '0;
        end else begin
            snap_q <= snap_d;
            idx_q  <= idx_d;
            row_q  <= row_d;
            col_q  <= col_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: tb/tb_mnist_frame_reader.sv
// Directed bench for mnist_frame_reader: single cell, row wrap, backpressure,
// snapshot isolation, control (start/abort) and mid-stream reset.
module tb_mnist_frame_reader;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic         abort;
    logic [783:0] pixel_memory;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [9:0]   out_index;
    logic [4:0]   out_row;
    logic [4:0]   out_col;
    logic         out_last;
    logic         done;
    logic [9:0]   ones_count;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int beat_k   = 0;
    int cyc      = 0;
    logic [783:0] img_cur;
    logic [783:0] img_chk;
    logic [783:0] img_one;
    logic [783:0] img_zero;
    logic [783:0] img_full;

    // Clock: 50 MHz.
    always #10 clk = ~clk;

    mnist_frame_reader dut (
        .CLOCK_50     (clk),
        .resetn       (resetn),
        .start        (start),
        .abort        (abort),
        .pixel_memory (pixel_memory),
        .busy         (busy),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_row      (out_row),
        .out_col      (out_col),
        .out_last     (out_last),
        .done         (done),
        .ones_count   (ones_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0d expected %0d (beat %0d)", tag, obs, exp, beat_k);
        end
    endtask

    function automatic int count_to(input logic [783:0] img, input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(img[i]);
        return c;
    endfunction

    task automatic check_reset_state();
        check("rst_valid", out_valid, 0);
        check("rst_busy",  busy, 0);
        check("rst_done",  done, 0);
        check("rst_last",  out_last, 0);
        check("rst_data",  out_data, 0);
        check("rst_index", out_index, 0);
        check("rst_row",   out_row, 0);
        check("rst_col",   out_col, 0);
        check("rst_ones",  ones_count, 0);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the first beat.
    task automatic start_frame(input logic [783:0] img, input logic [783:0] post);
        pixel_memory = img;
        img_cur      = img;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        pixel_memory = post;
        beat_k       = 0;
        cyc          = 1;
        check("ones_clear", ones_count, 0);
    endtask

    // Consume beats until beat_k reaches n. mode 0: always ready;
    // mode 1: alternating ready with random bursts.
    task automatic run_beats(input int n, input int mode);
        int   guard = 0;
        logic rdy;
        while (beat_k < n && guard < 4000) begin
            check("out_valid", out_valid, 1);
            check("busy",      busy, 1);
            check("done_low",  done, 0);
            check("out_index", out_index, beat_k);
            check("out_row",   out_row, beat_k / 28);
            check("out_col",   out_col, beat_k % 28);
            check("index_rc",  out_index, int'(out_row) * 28 + int'(out_col));
            check("out_data",  out_data, img_cur[beat_k] ? 255 : 0);
            check("out_last",  out_last, (beat_k == 783) ? 1 : 0);
            if (mode == 0)      rdy = 1'b1;
            else if (cyc % 2)   rdy = ($urandom_range(0, 4) != 0);
            else                rdy = ($urandom_range(0, 4) == 0);
            out_ready = rdy;
            @(negedge clk);
            cyc++;
            guard++;
            if (rdy) beat_k++;
        end
        out_ready = 1'b0;
        if (beat_k < n) check("beat_timeout", beat_k, n);
    endtask

    // At the negedge after the last transfer: DONE cycle then back to IDLE.
    task automatic finish_frame(input int exp_ones, input int exp_cyc);
        check("done_pulse", done, 1);
        check("done_valid", out_valid, 0);
        check("done_busy",  busy, 1);
        check("done_ones",  ones_count, exp_ones);
        if (exp_cyc > 0) check("done_cycle", cyc, exp_cyc);
        @(negedge clk);
        check("idle_done",  done, 0);
        check("idle_busy",  busy, 0);
        check("idle_valid", out_valid, 0);
        check("idle_ones",  ones_count, exp_ones);
    endtask

    initial begin
        img_zero = '0;
        img_full = '1;
        img_one  = '0;
        img_one[29] = 1'b1;
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img_chk[r*28 + c] = ((r + c) % 2 == 1);
        img_cur      = '0;
        resetn       = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        out_ready    = 1'b0;
        pixel_memory = '0;
        repeat (2) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;
        @(negedge clk);

        // Single set cell at (1,1); also covers row wrap at beats 27/28.
        start_frame(img_one, img_one);
        run_beats(784, 0);
        finish_frame(1, 785);

        // Checkerboard under backpressure.
        start_frame(img_chk, img_chk);
        run_beats(784, 1);
        finish_frame(392, 0);

        // Snapshot isolation: memory goes all-ones right after the snapshot.
        start_frame(img_zero, img_full);
        run_beats(784, 0);
        finish_frame(0, 785);
        start_frame(img_full, img_full);
        run_beats(784, 0);
        finish_frame(784, 785);

        // Abort at index 100 with out_ready high: beat 100 is not counted.
        start_frame(img_chk, img_chk);
        run_beats(100, 0);
        abort     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        abort     = 1'b0;
        out_ready = 1'b0;
        check("abort_valid", out_valid, 0);
        check("abort_done",  done, 0);
        check("abort_busy",  busy, 0);
        check("abort_ones",  ones_count, count_to(img_chk, 100));
        @(negedge clk);
        check("abort_done2", done, 0);
        check("abort_ones2", ones_count, count_to(img_chk, 100));

        // Restart after abort; a start pulse at index 300 is ignored.
        start_frame(img_chk, img_chk);
        run_beats(300, 0);
        start = 1'b1;
        run_beats(301, 0);
        start = 1'b0;
        run_beats(784, 0);
        finish_frame(392, 785);

        // Reset held two cycles mid-stream at index 50.
        start_frame(img_chk, img_chk);
        run_beats(50, 0);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state();
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_valid", out_valid, 0);
        check("post_rst_done",  done, 0);
        start_frame(img_chk, img_chk);
        run_beats(784, 0);
        finish_frame(392, 785);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
